// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between a write
// requester and a read requester. Grants are combinational, RAM controls are
// registered, and read data returns two cycles after its grant.
module ram_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;
  typedef enum logic {WIN_WR = 1'b0, WIN_RD = 1'b1} win_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_d;
  win_t   last_win;
  logic   contested;

  // Grant selection: a lone request wins; a contest goes to the last loser.
  always_comb begin
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    contested = wr_req && rd_req;
    if (!rst) begin
      if (contested) begin
        wr_gnt = (last_win == WIN_RD);
        rd_gnt = (last_win == WIN_WR);
      end else begin
        wr_gnt = wr_req;
        rd_gnt = rd_req;
      end
    end
  end

  // Next issue state follows the access granted this cycle.
  always_comb begin
    state_d = ST_IDLE;
    if (wr_gnt) begin
      state_d = ST_WR;
    end else if (rd_gnt) begin
      state_d = ST_RD;
    end
  end

  // Issue state register; mem_en/mem_we are loaded alongside it so they are
  // clean flop outputs rather than a decode of the encoded state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      state  <= state_d;
      mem_en <= (state_d != ST_IDLE);
      mem_we <= (state_d == ST_WR);
    end
  end

  // Priority pointer moves only when both ports competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_win <= WIN_RD;
    end else if (contested) begin
      last_win <= wr_gnt ? WIN_WR : WIN_RD;
    end
  end

  // RAM address/data capture from the granted port; held while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (wr_gnt) begin
      mem_addr  <= wr_addr;
      mem_wdata <= wr_data;
    end else if (rd_gnt) begin
      mem_addr  <= rd_addr;
    end
  end

  // Read return strobe: one cycle after the read is presented to the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == ST_RD);
    end
  end

  assign rd_data = rd_valid ? mem_rdata : '0;

  // Saturating grant counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_gnt && (wr_cnt != CNT_MAX)) begin
        wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      end
      if (rd_gnt && (rd_cnt != CNT_MAX)) begin
        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
